tt_sweep_ctrl: RTL and testbench

Sequencer for exhaustive truth-table checking of a combinational Boolean function and its reduced or optimized implementation. It drives every input vector 0..2^N_IN−1 into two DUT copies, A (original) and B (reduced). It samples both outputs after a fixed latency and accumulates the onset count of A, the mismatch count, and the first failing vector. It sits between the bench or host control and the pair of function netlists under comparison, and is the single owner of their shared input bus.

---
 rtl/tt_sweep_if.sv | 28 ++
 rtl/tt_sweep_ctrl.sv | 116 +++++++++++
 tb/tb_tt_sweep_ctrl.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/tt_sweep_if.sv
// rtl/tt_sweep_if.sv - host/DUT-side bus of the truth-table sweep controller
interface tt_sweep_if #(
    parameter int N_IN = 14
);
    logic              start;
    logic              abort;
    logic [N_IN-1:0]   dut_x;
    logic              dut_a_y;
    logic              dut_b_y;
    logic              busy;
    logic              done;
    logic              mismatch;
    logic [N_IN-1:0]   first_fail;
    logic [N_IN:0]     onset_cnt;
    logic [N_IN:0]     fail_cnt;

    // Host/netlist side: issues commands and returns the two function outputs.
    modport master (
        output start, abort, dut_a_y, dut_b_y,
        input  dut_x, busy, done, mismatch, first_fail, onset_cnt, fail_cnt
    );

    // Controller side: owns the shared input vector and the result registers.
    modport slave (
        input  start, abort, dut_a_y, dut_b_y,
        output dut_x, busy, done, mismatch, first_fail, onset_cnt, fail_cnt
    );
endinterface

// File: rtl/tt_sweep_ctrl.sv
// rtl/tt_sweep_ctrl.sv - exhaustive truth-table sweep comparing two function netlists
module tt_sweep_ctrl #(
    parameter int N_IN = 14,
    parameter int LAT  = 1
) (
    input  logic     clk,
    input  logic     rst_n,
    tt_sweep_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam logic [N_IN-1:0] X_LAST_M1 = {{(N_IN-1){1'b1}}, 1'b0};
    localparam logic [2:0]      LAT_C     = 3'(LAT);

    state_t            state;
    // Stage 0 is the vector currently on dut_x; stage LAT-1 retires on the next edge.
    logic [LAT-1:0]    pv;
    logic [N_IN-1:0]   px [LAT];
    logic [2:0]        drain_cnt;
    logic              busy_r;
    logic              done_r;
    logic              mm_r;
    logic [N_IN-1:0]   ff_r;
    logic [N_IN:0]     onset_r;
    logic [N_IN:0]     fail_r;

    logic              ret;
    logic [N_IN-1:0]   ret_x;
    logic              diff;

    assign ret   = pv[LAT-1];
    assign ret_x = px[LAT-1];
    assign diff  = bus.dut_a_y ^ bus.dut_b_y;

    assign bus.dut_x      = px[0];
    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.mismatch   = mm_r;
    assign bus.first_fail = ff_r;
    assign bus.onset_cnt  = onset_r;
    assign bus.fail_cnt   = fail_r;

    // Sweep FSM: issues vectors, shifts the alignment pipe and retires results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pv        <= '0;
            for (int j = 0; j < LAT; j++) px[j] <= '0;
            drain_cnt <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            mm_r      <= 1'b0;
            ff_r      <= '0;
            onset_r   <= '0;
            fail_r    <= '0;
        end else begin
            done_r <= 1'b0;
            for (int j = 1; j < LAT; j++) begin
                pv[j] <= pv[j-1];
                px[j] <= px[j-1];
            end
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state   <= RUN;
                        busy_r  <= 1'b1;
                        px[0]   <= '0;
                        pv[0]   <= 1'b1;
                        mm_r    <= 1'b0;
                        ff_r    <= '0;
                        onset_r <= '0;
                        fail_r  <= '0;
                    end
                end
                RUN, DRAIN: begin
                    if (bus.abort) begin
                        // Flush without retiring; partial counts stay visible.
                        state  <= IDLE;
                        busy_r <= 1'b0;
                        pv     <= '0;
                    end else begin
                        if (ret) begin
                            onset_r <= onset_r + {{N_IN{1'b0}}, bus.dut_a_y};
                            if (diff) begin
                                fail_r <= fail_r + {{N_IN{1'b0}}, 1'b1};
                                if (!mm_r) begin
                                    mm_r <= 1'b1;
                                    ff_r <= ret_x;
                                end
                            end
                        end
                        if (state == RUN) begin
                            px[0] <= px[0] + {{(N_IN-1){1'b0}}, 1'b1};
                            pv[0] <= 1'b1;
                            if (px[0] == X_LAST_M1) begin
                                state     <= DRAIN;
                                drain_cnt <= '0;
                            end
                        end else begin
                            // dut_x holds the last vector; only the pipe drains.
                            pv[0] <= 1'b0;
                            if (drain_cnt == LAT_C) begin
                                state  <= IDLE;
                                busy_r <= 1'b0;
                                done_r <= 1'b1;
                            end else begin
                                drain_cnt <= drain_cnt + 3'd1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// tb/tb_tt_sweep_ctrl.sv - self-checking bench for tt_sweep_ctrl
module tb_tt_sweep_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] inj0 = '0;
    logic start_r [3];
    logic abort_r [3];

    tt_sweep_if #(.N_IN(4)) if0 ();
    tt_sweep_if #(.N_IN(4)) if1 ();
    tt_sweep_if #(.N_IN(4)) if2 ();

    tt_sweep_ctrl #(.N_IN(4), .LAT(1)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    tt_sweep_ctrl #(.N_IN(4), .LAT(3)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    tt_sweep_ctrl #(.N_IN(4), .LAT(1)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    assign if0.start = start_r[0];
    assign if1.start = start_r[1];
    assign if2.start = start_r[2];
    assign if0.abort = abort_r[0];
    assign if1.abort = abort_r[1];
    assign if2.abort = abort_r[2];

    function automatic logic f(input logic [3:0] x);
        return x[0] & x[1];
    endfunction

    // u0: combinational A, B = A with injectable inversions
    assign if0.dut_a_y = f(if0.dut_x);
    assign if0.dut_b_y = f(if0.dut_x) ^ inj0[if0.dut_x];

    // u1: both functions behind two register stages; u2: pipelined A, combinational B
    logic p1a, p2a, p1b, p2b, q1, q2;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1a <= 1'b0; p2a <= 1'b0; p1b <= 1'b0; p2b <= 1'b0; q1 <= 1'b0; q2 <= 1'b0;
        end else begin
            p1a <= f(if1.dut_x); p2a <= p1a;
            p1b <= f(if1.dut_x); p2b <= p1b;
            q1  <= f(if2.dut_x); q2  <= q1;
        end
    end
    assign if1.dut_a_y = p2a;
    assign if1.dut_b_y = p2b;
    assign if2.dut_a_y = q2;
    assign if2.dut_b_y = f(if2.dut_x);

    logic       done_w [3];
    logic       busy_w [3];
    logic       mm_w   [3];
    logic [3:0] x_w    [3];
    logic [3:0] ff_w   [3];
    logic [4:0] on_w   [3];
    logic [4:0] fl_w   [3];
    assign done_w[0] = if0.done;       assign done_w[1] = if1.done;       assign done_w[2] = if2.done;
    assign busy_w[0] = if0.busy;       assign busy_w[1] = if1.busy;       assign busy_w[2] = if2.busy;
    assign mm_w[0]   = if0.mismatch;   assign mm_w[1]   = if1.mismatch;   assign mm_w[2]   = if2.mismatch;
    assign x_w[0]    = if0.dut_x;      assign x_w[1]    = if1.dut_x;      assign x_w[2]    = if2.dut_x;
    assign ff_w[0]   = if0.first_fail; assign ff_w[1]   = if1.first_fail; assign ff_w[2]   = if2.first_fail;
    assign on_w[0]   = if0.onset_cnt;  assign on_w[1]   = if1.onset_cnt;  assign on_w[2]   = if2.onset_cnt;
    assign fl_w[0]   = if0.fail_cnt;   assign fl_w[1]   = if1.fail_cnt;   assign fl_w[2]   = if2.fail_cnt;

    typedef struct {
        int onset;
        int fail;
        int mm;
        int ff;
        int edges;
        int busy_cy;
        bit fail_nz_only;
    } exp_t;
    exp_t sb [$];

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference results for a complete sweep of controller u.
    function automatic exp_t model(input int u);
        exp_t e;
        logic [3:0] kx;
        e.onset = 0; e.fail = 0; e.mm = 0; e.ff = 0;
        e.edges = 16 + ((u == 1) ? 3 : 1);
        e.busy_cy = e.edges;
        e.fail_nz_only = (u == 2);
        for (int k = 0; k < 16; k++) begin
            kx = 4'(k);
            if (f(kx)) e.onset++;
            if (u == 0 && inj0[k]) begin
                e.fail++;
                if (e.mm == 0) begin
                    e.mm = 1;
                    e.ff = k;
                end
            end
        end
        return e;
    endfunction

    task automatic compare_results(input int u, input exp_t e, input int edges, input int busy_cy);
        check($sformatf("u%0d_done_edge", u), edges, e.edges);
        check($sformatf("u%0d_busy_cycles", u), busy_cy, e.busy_cy);
        if (e.fail_nz_only) begin
            check($sformatf("u%0d_fail_nonzero", u), int'(fl_w[u] != 0), 1);
        end else begin
            check($sformatf("u%0d_onset", u), int'(on_w[u]), e.onset);
            check($sformatf("u%0d_fail", u), int'(fl_w[u]), e.fail);
            check($sformatf("u%0d_mismatch", u), int'(mm_w[u]), e.mm);
            check($sformatf("u%0d_first_fail", u), int'(ff_w[u]), e.ff);
        end
    endtask

    // Full sweep on controller u; a spurious start is pulsed after edge 'extra' when nonzero.
    task automatic run_sweep(input int u, input int extra);
        exp_t e;
        int edges;
        int busy_cy;
        sb.push_back(model(u));
        @(posedge clk); #1 start_r[u] = 1'b1;
        @(posedge clk); #1 start_r[u] = 1'b0;
        edges = 0;
        busy_cy = int'(busy_w[u]);
        while (!done_w[u] && edges < 100) begin
            @(posedge clk); #1;
            edges++;
            busy_cy += int'(busy_w[u]);
            start_r[u] = (extra != 0 && edges == extra);
        end
        start_r[u] = 1'b0;
        if (edges >= 100) check($sformatf("u%0d_timeout", u), 0, 1);
        e = sb.pop_front();
        compare_results(u, e, edges, busy_cy);
        @(posedge clk); #1;
        check($sformatf("u%0d_done_single", u), int'(done_w[u]), 0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_x"}, int'(x_w[0]), 0);
        check({tag, "_busy"}, int'(busy_w[0]), 0);
        check({tag, "_done"}, int'(done_w[0]), 0);
        check({tag, "_mm"}, int'(mm_w[0]), 0);
        check({tag, "_ff"}, int'(ff_w[0]), 0);
        check({tag, "_onset"}, int'(on_w[0]), 0);
        check({tag, "_fail"}, int'(fl_w[0]), 0);
    endtask

    task automatic wait_x(input int v);
        int n;
        n = 0;
        while (x_w[0] != 4'(v) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) check("wait_x_timeout", 0, 1);
    endtask

    initial begin
        exp_t e;
        int edges, busy_cy, dones;
        for (int i = 0; i < 3; i++) begin
            start_r[i] = 1'b0;
            abort_r[i] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1 check_zero("reset");
        rst_n = 1'b1;

        // agreeing DUTs
        run_sweep(0, 0);

        // injected mismatches at vectors 5 and 9
        inj0 = 16'h0220;
        run_sweep(0, 0);
        inj0 = '0;

        // pipelined DUTs, aligned and misaligned controllers
        run_sweep(1, 0);
        run_sweep(2, 0);

        // abort when dut_x = 6
        @(posedge clk); #1 start_r[0] = 1'b1;
        @(posedge clk); #1 start_r[0] = 1'b0;
        wait_x(6);
        abort_r[0] = 1'b1;
        @(posedge clk); #1 abort_r[0] = 1'b0;
        check("abort_busy", int'(busy_w[0]), 0);
        check("abort_onset", int'(on_w[0]), 1);
        check("abort_onset_le6", int'(on_w[0] <= 5'd6), 1);
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            dones += int'(done_w[0]);
        end
        check("abort_no_done", dones, 0);
        run_sweep(0, 0);

        // start pulsed while busy has no effect
        run_sweep(0, 5);

        // start held high across done
        sb.push_back(model(0));
        @(posedge clk); #1 start_r[0] = 1'b1;
        edges = 0;
        while (!done_w[0] && edges < 100) begin
            @(posedge clk); #1;
            edges++;
        end
        if (edges >= 100) check("hold_timeout", 0, 1);
        @(posedge clk); #1;
        check("hold_restart_busy", int'(busy_w[0]), 1);
        check("hold_restart_x", int'(x_w[0]), 0);
        start_r[0] = 1'b0;
        edges = 0;
        busy_cy = 1;
        dones = 0;
        while (!done_w[0] && edges < 100) begin
            @(posedge clk); #1;
            edges++;
            busy_cy += int'(busy_w[0]);
        end
        if (edges >= 100) check("hold2_timeout", 0, 1);
        for (int i = 0; i < 3; i++) begin
            dones += int'(done_w[0]);
            @(posedge clk); #1;
        end
        check("hold_done_once", dones, 1);
        e = sb.pop_front();
        compare_results(0, e, edges, busy_cy);

        // asynchronous reset mid-sweep at dut_x = 10
        inj0 = 16'h0220;
        @(posedge clk); #1 start_r[0] = 1'b1;
        @(posedge clk); #1 start_r[0] = 1'b0;
        wait_x(10);
        check("pre_reset_onset", int'(on_w[0]), 2);
        #1 rst_n = 1'b0;
        #1 check_zero("async_rst");
        @(negedge clk) rst_n = 1'b1;
        run_sweep(0, 0);
        inj0 = '0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
